// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional parity bit, then 1 or 2 stop bits. The internal baud counter sets
// the bit timing, upstream uses a valid/ready handshake, and tx_done pulses
// once at the end of each frame.
module uart_tx_param #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned     BaudW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       DataLast = 4'(DATA_BITS - 1);
    localparam logic [3:0]       StopLast = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                 state_q, state_d;
    logic [BaudW-1:0]       baud_q, baud_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic                   txd_q, txd_d;
    logic                   done_c;
    logic                   baud_end;
    logic                   accept;

    assign baud_end = (baud_q == BaudLast);
    assign accept   = tx_valid && tx_ready;

    // Next-state logic; bit_q counts data bits in StData and stop bits in StStop.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        done_c   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shift_d  = tx_data;
                    // Parity fixed at acceptance from the unshifted word.
                    parity_d = (^tx_data) ^ (PARITY_ODD != 0);
                    baud_d   = '0;
                    bit_d    = '0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == DataLast) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StParity: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StStop;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == StopLast) begin
                        bit_d   = '0;
                        done_c  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level is derived from the next state so txd changes with the state register.
    always_comb begin
        txd_d = 1'b1;
        unique case (state_d)
            StStart:  txd_d = 1'b0;
            StData:   txd_d = shift_d[0];
            StParity: txd_d = parity_d;
            default:  txd_d = 1'b1;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            txd_q    <= txd_d;
        end
    end

    // Ready and done are masked by rst so neither asserts while reset is held.
    assign txd      = txd_q;
    assign tx_busy  = (state_q != StIdle);
    assign tx_ready = (state_q == StIdle) && !rst;
    assign tx_done  = done_c && !rst;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: four instances with different frame
// formats, random words checked cycle by cycle against a frame built as a bit list.
module tb_uart_tx_param;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] valid = '0;
    logic [8:0] data [4];
    logic [3:0] ready, txd, busy, done;

    int unsigned cfg_bits [4] = '{8, 8, 8, 5};
    int unsigned cfg_par  [4] = '{0, 1, 1, 0};
    int unsigned cfg_odd  [4] = '{0, 0, 1, 0};
    int unsigned cfg_stop [4] = '{1, 1, 1, 2};

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                    .STOP_BITS(1)) u_d0 (
        .clk(clk), .rst(rst), .tx_valid(valid[0]), .tx_data(data[0][7:0]),
        .tx_ready(ready[0]), .txd(txd[0]), .tx_busy(busy[0]), .tx_done(done[0]));
    uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                    .STOP_BITS(1)) u_d1 (
        .clk(clk), .rst(rst), .tx_valid(valid[1]), .tx_data(data[1][7:0]),
        .tx_ready(ready[1]), .txd(txd[1]), .tx_busy(busy[1]), .tx_done(done[1]));
    uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1),
                    .STOP_BITS(1)) u_d2 (
        .clk(clk), .rst(rst), .tx_valid(valid[2]), .tx_data(data[2][7:0]),
        .tx_ready(ready[2]), .txd(txd[2]), .tx_busy(busy[2]), .tx_done(done[2]));
    uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0),
                    .STOP_BITS(2)) u_d3 (
        .clk(clk), .rst(rst), .tx_valid(valid[3]), .tx_data(data[3][4:0]),
        .tx_ready(ready[3]), .txd(txd[3]), .tx_busy(busy[3]), .tx_done(done[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference frame as a list of line levels, one entry per bit period.
    task automatic build_frame(input int idx, input logic [8:0] word, output bit q[$]);
        bit p;
        q = {};
        q.push_back(1'b0);
        p = 1'b0;
        for (int i = 0; i < int'(cfg_bits[idx]); i++) begin
            q.push_back(word[i]);
            p ^= word[i];
        end
        if (cfg_par[idx] != 0) q.push_back(p ^ (cfg_odd[idx] != 0));
        for (int s = 0; s < int'(cfg_stop[idx]); s++) q.push_back(1'b1);
    endtask

    task automatic idle_check(input int idx, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("idle_txd d%0d", idx), 32'(txd[idx]), 32'd1);
            check($sformatf("idle_busy d%0d", idx), 32'(busy[idx]), 32'd0);
            check($sformatf("idle_done d%0d", idx), 32'(done[idx]), 32'd0);
        end
    endtask

    // Present a word, then check every cycle of its frame. 'noise' pulses
    // tx_valid with junk mid-frame; 'keep' leaves tx_valid high with next_word.
    task automatic send(input int idx, input logic [8:0] word, input bit noise,
                        input bit keep, input logic [8:0] next_word);
        bit q[$];
        int len, n;
        build_frame(idx, word, q);
        len = q.size() * C;
        n = 0;
        while (!ready[idx] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("ready_idle d%0d", idx), 32'(ready[idx]), 32'd1);
        check($sformatf("txd_idle d%0d", idx), 32'(txd[idx]), 32'd1);
        valid[idx] = 1'b1;
        data[idx]  = word;
        @(negedge clk);
        valid[idx] = keep;
        data[idx]  = keep ? next_word : 9'($urandom);
        for (int k = 0; k < len; k++) begin
            check($sformatf("txd d%0d w%0h k%0d", idx, word, k), 32'(txd[idx]), 32'(q[k / C]));
            check($sformatf("busy d%0d k%0d", idx, k), 32'(busy[idx]), 32'd1);
            check($sformatf("ready d%0d k%0d", idx, k), 32'(ready[idx]), 32'd0);
            check($sformatf("done d%0d k%0d", idx, k), 32'(done[idx]), 32'(k == len - 1));
            if (noise && !keep && k < len - 2) begin
                valid[idx] = (k % 7 == 3);
                data[idx]  = (k < 8) ? 9'h033 : 9'($urandom);
            end
            @(negedge clk);
        end
        valid[idx] = keep;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) data[i] = '0;
        // Reset held with tx_valid high: nothing may be accepted.
        valid[0] = 1'b1;
        data[0]  = 9'h0A5;
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(txd[0]), 32'd1);
        check("rst_ready", 32'(ready[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_done", 32'(done[0]), 32'd0);
        rst      = 1'b0;
        valid[0] = 1'b0;
        #1;
        check("ready_after_rst", 32'(ready[0]), 32'd1);
        check("busy_after_rst", 32'(busy[0]), 32'd0);

        // Directed frames.
        send(0, 9'h0A5, 1'b1, 1'b0, 9'h0);      // junk tx_valid pulses while busy
        idle_check(0, 3 * C);                  // 0x33 must not appear
        send(1, 9'h007, 1'b0, 1'b0, 9'h0);
        send(2, 9'h007, 1'b0, 1'b0, 9'h0);
        send(1, 9'h000, 1'b0, 1'b0, 9'h0);
        send(3, 9'h01F, 1'b0, 1'b0, 9'h0);
        send(0, 9'h055, 1'b0, 1'b1, 9'h0AA);   // back-to-back
        send(0, 9'h0AA, 1'b0, 1'b0, 9'h0);
        idle_check(0, 2);

        // Reset during data bit 3 of 0xF0.
        begin
            bit q[$];
            build_frame(0, 9'h0F0, q);
            @(negedge clk);
            valid[0] = 1'b1;
            data[0]  = 9'h0F0;
            @(negedge clk);
            valid[0] = 1'b0;
            for (int k = 0; k < 4 * C + 1; k++) begin
                check($sformatf("rstf_txd k%0d", k), 32'(txd[0]), 32'(q[k / C]));
                @(negedge clk);
            end
            rst = 1'b1;
            #1;
            check("mid_rst_ready", 32'(ready[0]), 32'd0);
            @(negedge clk);
            rst = 1'b0;
            #1;
            check("post_rst_txd", 32'(txd[0]), 32'd1);
            check("post_rst_busy", 32'(busy[0]), 32'd0);
            check("post_rst_ready", 32'(ready[0]), 32'd1);
            idle_check(0, 12 * C);
        end

        // Random words on every format.
        for (int r = 0; r < 6; r++) begin
            for (int d = 0; d < 4; d++) begin
                logic [8:0] w;
                w = 9'($urandom) & ((9'd1 << cfg_bits[d]) - 9'd1);
                send(d, w, bit'($urandom_range(0, 1)), 1'b0, 9'h0);
                idle_check(d, 2);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
